// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path.
// Contents:
//   CONV_DATA_WIDTH / CONV_OUT_WIDTH : default sample widths before/after narrowing
//   fa_state_t                       : filter_arbiter FSM states
//   sat_narrow()                     : narrow a CONV_DATA_WIDTH sample to CONV_OUT_WIDTH,
//                                      either by truncation or by signed saturation
package conv_pkg;

    localparam int CONV_DATA_WIDTH = 16;
    localparam int CONV_OUT_WIDTH  = 8;

    typedef enum logic [0:0] {
        FA_IDLE  = 1'b0,
        FA_BURST = 1'b1
    } fa_state_t;

    // Bits [W-1:OW-1] must all equal the sign bit for the value to fit in OW bits.
    function automatic logic [CONV_OUT_WIDTH-1:0] sat_narrow(
        input logic [CONV_DATA_WIDTH-1:0] value,
        input logic                       sat_en
    );
        logic [CONV_DATA_WIDTH-CONV_OUT_WIDTH:0] upper;
        logic [CONV_OUT_WIDTH-1:0]               result;
        upper = value[CONV_DATA_WIDTH-1:CONV_OUT_WIDTH-1];
        if (sat_en && !value[CONV_DATA_WIDTH-1] && (upper != '0)) begin
            result = {1'b0, {(CONV_OUT_WIDTH-1){1'b1}}};
        end else if (sat_en && value[CONV_DATA_WIDTH-1] && (upper != '1)) begin
            result = {1'b1, {(CONV_OUT_WIDTH-1){1'b0}}};
        end else begin
            result = value[CONV_OUT_WIDTH-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr_i, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req_i     : request vector
//   ptr_i     : search start index (must be < NUM_REQ)
//   gnt_oh_o  : one-hot grant (all zero when no request)
//   gnt_idx_o : index of the granted request (0 when no request)
//   any_o     : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    int   cand;
    logic found;

    // Rotating priority search starting at the pointer.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                gnt_oh_o[cand]  = 1'b1;
                gnt_idx_o       = IDX_W'(cand);
            end else begin
                found = found;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/filter_arbiter.sv
// Shares one narrowing/output stage among NUM_CH channel result streams.
// A channel is granted round-robin and keeps the grant for exactly BURST_LEN
// accepted beats; each beat is narrowed to DATA_WIDTH/2 bits and registered
// together with its channel id and a last-of-burst flag.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ivalid   : per-channel valid
//   ivalue   : per-channel signed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   iready   : per-channel accept (at most one bit set)
//   ovalid   : output beat valid
//   oready   : downstream accept
//   ovalue   : narrowed sample
//   ochan    : source channel of ovalue
//   olast    : final beat of the burst
module filter_arbiter
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int BURST_LEN  = 4,
    parameter int SATURATE   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ivalid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ivalue,
    output logic [NUM_CH-1:0]            iready,
    output logic                         ovalid,
    input  logic                         oready,
    output logic [DATA_WIDTH/2-1:0]      ovalue,
    output logic [$clog2(NUM_CH)-1:0]    ochan,
    output logic                         olast
);

    localparam int OW = DATA_WIDTH / 2;
    localparam int IW = $clog2(NUM_CH);
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    fa_state_t         state_q, state_d;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     grant_q;
    logic [NUM_CH-1:0] grant_oh_q;
    logic [CW-1:0]     beat_cnt_q;
    logic              ovalid_q;
    logic [OW-1:0]     ovalue_q;
    logic [IW-1:0]     ochan_q;
    logic              olast_q;

    logic [NUM_CH-1:0]     arb_oh_s;
    logic [IW-1:0]         arb_idx_s;
    logic                  arb_any_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;
    logic [OW-1:0]         narrow_s;
    logic                  out_free_s;
    logic                  xfer_s;
    logic                  last_beat_s;

    rr_arbiter #(
        .NUM_REQ (NUM_CH),
        .IDX_W   (IW)
    ) u_rr_arbiter (
        .req_i     (ivalid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (arb_oh_s),
        .gnt_idx_o (arb_idx_s),
        .any_o     (arb_any_s)
    );

    // Output register can take a new beat when empty or being drained this cycle.
    assign out_free_s  = !ovalid_q || oready;
    assign xfer_s      = (state_q == FA_BURST) && ((grant_oh_q & ivalid) != '0) && out_free_s;
    assign last_beat_s = (beat_cnt_q == CW'(BURST_LEN - 1));
    assign gnt_data_s  = ivalue[grant_q*DATA_WIDTH +: DATA_WIDTH];

    generate
        if (DATA_WIDTH == CONV_DATA_WIDTH) begin : g_pkg_narrow
            assign narrow_s = sat_narrow(gnt_data_s, (SATURATE != 0));
        end else begin : g_generic_narrow
            // Same narrowing rule as sat_narrow(), for non-default widths.
            always_comb begin
                if ((SATURATE != 0) && !gnt_data_s[DATA_WIDTH-1] &&
                    (gnt_data_s[DATA_WIDTH-1:OW-1] != '0)) begin
                    narrow_s = {1'b0, {(OW-1){1'b1}}};
                end else if ((SATURATE != 0) && gnt_data_s[DATA_WIDTH-1] &&
                             (gnt_data_s[DATA_WIDTH-1:OW-1] != '1)) begin
                    narrow_s = {1'b1, {(OW-1){1'b0}}};
                end else begin
                    narrow_s = gnt_data_s[OW-1:0];
                end
            end
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE waits for any request, BURST ends on the final beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FA_IDLE: begin
                if (arb_any_s) begin
                    state_d = FA_BURST;
                end else begin
                    state_d = FA_IDLE;
                end
            end
            FA_BURST: begin
                if (xfer_s && last_beat_s) begin
                    state_d = FA_IDLE;
                end else begin
                    state_d = FA_BURST;
                end
            end
            default: state_d = FA_IDLE;
        endcase
    end

    // FSM outputs: only the locked channel sees ready, and only during a burst.
    always_comb begin
        iready = '0;
        if (state_q == FA_BURST) begin
            iready = grant_oh_q & {NUM_CH{out_free_s}};
        end else begin
            iready = '0;
        end
    end

    // Grant, beat counter, round-robin pointer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
            beat_cnt_q <= '0;
            ovalid_q   <= 1'b0;
            ovalue_q   <= '0;
            ochan_q    <= '0;
            olast_q    <= 1'b0;
        end else begin
            if ((state_q == FA_IDLE) && arb_any_s) begin
                grant_q    <= arb_idx_s;
                grant_oh_q <= arb_oh_s;
                beat_cnt_q <= '0;
            end
            if (xfer_s) begin
                ovalid_q <= 1'b1;
                ovalue_q <= narrow_s;
                ochan_q  <= grant_q;
                olast_q  <= last_beat_s;
                if (last_beat_s) begin
                    beat_cnt_q <= '0;
                    rr_ptr_q   <= (grant_q == IW'(NUM_CH - 1)) ? '0 : grant_q + IW'(1);
                end else begin
                    beat_cnt_q <= beat_cnt_q + CW'(1);
                end
            end else if (oready) begin
                ovalid_q <= 1'b0;
            end
        end
    end

    assign ovalid = ovalid_q;
    assign ovalue = ovalue_q;
    assign ochan  = ochan_q;
    assign olast  = olast_q;

endmodule

// File: doc/filter_arbiter.md
Name: filter_arbiter

Overview:
- Shares one output filter/narrowing stage among NUM_CH convolution channel result streams.
- Grants one channel at a time, round-robin, for a fixed burst of BURST_LEN beats.
- Narrows each accepted signed DATA_WIDTH value to DATA_WIDTH/2 bits and registers it, tagged with channel id and last-of-burst flag.
- Sits between the per-channel conv accumulators and the shared output buffer writer.

Parameters:
- DATA_WIDTH, 16, input sample width (signed); output width is DATA_WIDTH/2.
- NUM_CH, 4, number of requesting channels (≥2).
- BURST_LEN, 4, beats transferred per grant (≥1).
- SATURATE, 0, 0 = keep low DATA_WIDTH/2 bits (plain truncation); 1 = signed saturation to DATA_WIDTH/2 range.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ivalid  input  NUM_CH  per-channel data valid.
- ivalue  input  NUM_CH*DATA_WIDTH  per-channel signed data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- iready  output  NUM_CH  per-channel accept; at most one bit high.
- ovalid  output  1  output beat valid.
- oready  input  1  downstream accept.
- ovalue  output  DATA_WIDTH/2  signed narrowed value.
- ochan  output  $clog2(NUM_CH)  source channel of ovalue.
- olast  output  1  final beat of the current burst.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high. All state updates on posedge clk.
- Reset: state=IDLE, rr_ptr=0, beat_cnt=0, grant=0, iready=0, ovalid=0, ovalue=0, ochan=0, olast=0.
- FSM: IDLE, BURST.
- IDLE: if any ivalid, grant the first set ivalid at or after rr_ptr (wrapping), then go to BURST with beat_cnt=0. No ivalid: stay. No data accepted in IDLE.
- BURST: iready[grant] = !ovalid || oready; all other iready bits are 0.
- Beat transfer: ivalid[grant] && iready[grant] moves a beat into the output register:
  - ovalue <= narrow(ivalue[grant]); ochan <= grant; olast <= (beat_cnt==BURST_LEN-1); ovalid <= 1; beat_cnt increments.
- Burst end: on the transfer with beat_cnt==BURST_LEN-1, set rr_ptr <= (grant+1) mod NUM_CH, go to IDLE, beat_cnt <= 0. This gives one bubble cycle between bursts.
- Bursts are locked: the granted channel keeps the grant across ivalid gaps until BURST_LEN beats are accepted. Other requests wait.
- Output register:
  - Holds all output fields while ovalid && !oready.
  - ovalid clears on oready when no new beat loads in the same cycle.
  - Simultaneous oready and new beat: load the new beat, ovalid stays 1.
- Latency: 1 cycle from input transfer to ovalid. Full throughput within a burst when oready is held high.
- narrow(), SATURATE=0: the low DATA_WIDTH/2 bits, reinterpreted as signed.
- narrow(), SATURATE=1:
  - value > 2^(W/2-1)-1 gives 2^(W/2-1)-1.
  - value < -2^(W/2-1) gives -2^(W/2-1).
  - Otherwise the low bits.
- rr_ptr wrap: NUM_CH-1 wraps to 0. Arbitration search wraps the same way.
- rst mid-burst: the in-flight burst is abandoned and any registered output beat is dropped. Upstream must restart its burst.

Decomposition:
- Shared package conv_pkg holds:
  - constants CONV_DATA_WIDTH=16 and CONV_OUT_WIDTH=8;
  - an fa_state_t enum {FA_IDLE, FA_BURST};
  - a function sat_narrow(value, sat_en).
- One sub-module: rr_arbiter. It is a combinational round-robin pick of the first request at or after the pointer, and outputs a one-hot grant plus the index.
- The FSM, beat counter and output register stay in filter_arbiter.

Test Plan:
- Reset then idle: assert rst for 2 cycles with all ivalid=0 -> all outputs 0, iready=0 throughout and after release.
- Single channel, SATURATE=0: ch2 streams 16'h0123, 16'hFF80, 16'h0005, 16'h7FFF with oready=1 -> ovalue 8'h23, 8'h80, 8'h05, 8'hFF; ochan=2; olast only on the 4th beat; each ovalid 1 cycle after the transfer.
- Round-robin fairness: ivalid=4'b1111 held -> bursts granted in order ch0, ch1, ch2, ch3, ch0, 4 beats each, with one idle cycle between bursts.
- Backpressure: oready=0 for 3 cycles mid-burst on ch1 -> ovalue/ochan/olast stable, iready[1]=0 while ovalid && !oready. No beat lost or duplicated after oready returns.
- Saturation (SATURATE=1): inputs 16'h0123, 16'hFF00, 16'h007F, 16'hFF80 -> 8'h7F, 8'h80, 8'h7F, 8'h80.
- Reset mid-burst: rst after 2 beats of a ch3 burst -> next cycle ovalid=0, iready=0. After release with only ch1 valid, ch1 is granted (rr_ptr=0, search from 0) and receives a full 4-beat burst.
